// File: rtl/core_if_prefetch.sv
// Instruction fetch stage with a prefetch FIFO in front of decode.
// Credits keep granted-but-unanswered requests plus buffered words within FIFO_DEPTH.
module core_if_prefetch #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       INST_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid_in,
  input  logic [ADDR_W-1:0] redirect_addr_in,
  output logic              rom_req_out,
  output logic [ADDR_W-1:0] rom_addr_out,
  input  logic              rom_gnt_in,
  input  logic              rom_rvalid_in,
  input  logic [INST_W-1:0] rom_data_in,
  output logic              inst_valid_out,
  output logic [ADDR_W-1:0] inst_addr_out,
  output logic [INST_W-1:0] inst_out,
  input  logic              inst_ready_in
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_C = SUM_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;

  logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
  logic [INST_W-1:0] inst_mem_q [FIFO_DEPTH];

  logic [SUM_W-1:0]  credit_used;
  logic [ADDR_W-1:0] redirect_pc;
  logic              gnt;
  logic              drop;
  logic              push;
  logic              pop;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^redirect_addr_in[1:0];
  assign redirect_pc = {redirect_addr_in[ADDR_W-1:2], 2'b00};
  assign credit_used = SUM_W'(outstanding_q) + SUM_W'(count_q);

  assign inst_valid_out = (count_q != '0);
  assign inst_addr_out  = addr_mem_q[rd_ptr_q];
  assign inst_out       = inst_mem_q[rd_ptr_q];

  always_comb begin
    rom_req_out   = !rst && !redirect_valid_in && (credit_used < DEPTH_C);
    rom_addr_out  = fetch_pc_q;
    gnt           = rom_req_out && rom_gnt_in;
    drop          = rom_rvalid_in && (discard_q != '0);
    push          = rom_rvalid_in && !drop && !redirect_valid_in;
    pop           = inst_valid_out && inst_ready_in && !redirect_valid_in;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CNT_W'(gnt) - CNT_W'(rom_rvalid_in);
    if (redirect_valid_in) begin
      // Everything still in flight, minus this cycle's response, is stale.
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      discard_d  = outstanding_d;
    end else begin
      if (gnt) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (drop) discard_d = discard_q - CNT_W'(1);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        resp_pc_d = resp_pc_q + ADDR_W'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= resp_pc_q;
      inst_mem_q[wr_ptr_q] <= rom_data_in;
    end
  end

  a_rsp_has_credit: assert property (
    @(posedge clk) disable iff (rst) rom_rvalid_in |-> (outstanding_q != '0)
  ) else $error("ROM response with nothing outstanding");

endmodule

// File: tb/tb_core_if_prefetch.sv
// Bench for core_if_prefetch: in-order ROM model with variable latency
// and an address/instruction scoreboard on the decode side.
module tb_core_if_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid_in;
  logic [31:0] redirect_addr_in;
  logic        rom_req_out;
  logic [31:0] rom_addr_out;
  logic        rom_gnt_in;
  logic        rom_rvalid_in;
  logic [31:0] rom_data_in;
  logic        inst_valid_out;
  logic [31:0] inst_addr_out;
  logic [31:0] inst_out;
  logic        inst_ready_in;

  always #5 clk = ~clk;

  core_if_prefetch #(
    .ADDR_W(32), .INST_W(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid_in(redirect_valid_in),
    .redirect_addr_in(redirect_addr_in),
    .rom_req_out(rom_req_out),
    .rom_addr_out(rom_addr_out),
    .rom_gnt_in(rom_gnt_in),
    .rom_rvalid_in(rom_rvalid_in),
    .rom_data_in(rom_data_in),
    .inst_valid_out(inst_valid_out),
    .inst_addr_out(inst_addr_out),
    .inst_out(inst_out),
    .inst_ready_in(inst_ready_in)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rom_req_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rom_lat = 1;
  int          grants = 0;
  logic        mon_en = 1'b0;
  rom_req_t    rom_q[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ROM response side: drives rvalid/data for the coming edge
  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      rom_rvalid_in = 1'b0;
    end else if (rom_q.size() != 0 && rom_q[0].due <= cyc + 1) begin
      rom_rvalid_in = 1'b1;
      rom_data_in   = rom_fn(rom_q[0].addr);
      void'(rom_q.pop_front());
    end else begin
      rom_rvalid_in = 1'b0;
      rom_data_in   = '0;
    end
  end

  // ROM grant capture and decode-side scoreboard
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (!rst && rom_req_out && rom_gnt_in) begin
      rom_q.push_back('{addr: rom_addr_out, due: cyc + 1 + rom_lat});
      grants++;
    end
    if (mon_en && !rst && !redirect_valid_in && inst_valid_out && inst_ready_in) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pop addr=%h required=none", inst_addr_out);
      end else begin
        e = exp_q.pop_front();
        if (inst_addr_out !== e) begin
          bad++;
          $display("FAIL pop_addr got=%h required=%h", inst_addr_out, e);
        end
        total++;
        if (inst_out !== rom_fn(e)) begin
          bad++;
          $display("FAIL pop_inst got=%h required=%h", inst_out, rom_fn(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mon_en = 1'b0;
    redirect_valid_in = 1'b0;
    redirect_addr_in = '0;
    inst_ready_in = 1'b0;
    rom_gnt_in = 1'b0;
    exp_q.delete();
    tick();
    rom_q.delete();
    tick();
    tick();
    grants = 0;
    rst = 1'b0;
  endtask

  task automatic push_stream(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge clk);
      #2;
      n++;
    end
    mon_en = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain left=%0d required=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid_in = 1'b0;
    redirect_addr_in = '0;
    rom_gnt_in = 1'b1;
    inst_ready_in = 1'b1;
    rom_rvalid_in = 1'b0;
    rom_data_in = '0;
    tick();
    tick();
    @(negedge clk);
    total++;
    if (rom_req_out !== 1'b0) begin
      bad++; $display("FAIL rst_req got=%b required=0", rom_req_out);
    end
    total++;
    if (inst_valid_out !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b required=0", inst_valid_out);
    end
    total++;
    if (rom_addr_out !== 32'h0) begin
      bad++; $display("FAIL rst_addr got=%h required=0", rom_addr_out);
    end
    // Fill some state, then reset in the middle of it
    do_reset();
    rom_lat = 1;
    rom_gnt_in = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if (inst_valid_out !== 1'b0 || rom_req_out !== 1'b0) begin
      bad++;
      $display("FAIL midrst got=%b%b required=00", inst_valid_out, rom_req_out);
    end
    tick();
  endtask

  task automatic test_stream();
    int first = 0;
    do_reset();
    rom_lat = 1;
    rom_gnt_in = 1'b1;
    inst_ready_in = 1'b1;
    push_stream(32'h0, 8);
    mon_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (inst_valid_out && first == 0) first = k;
    end
    #1;
    total++;
    if (first != 3) begin
      bad++; $display("FAIL first_valid got=%0d required=3", first);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL stream_rate left=%0d required=0", exp_q.size());
    end
    wait_drain("stream", 20);
  endtask

  task automatic test_backpressure();
    do_reset();
    rom_lat = 1;
    rom_gnt_in = 1'b1;
    inst_ready_in = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    total++;
    if (grants != 4) begin
      bad++; $display("FAIL full_grants got=%0d required=4", grants);
    end
    total++;
    if (rom_req_out !== 1'b0) begin
      bad++; $display("FAIL full_req got=%b required=0", rom_req_out);
    end
    total++;
    if (inst_valid_out !== 1'b1 || inst_addr_out !== 32'h0) begin
      bad++;
      $display("FAIL full_head got=%b/%h required=1/0", inst_valid_out, inst_addr_out);
    end
    tick();
    push_stream(32'h0, 10);
    mon_en = 1'b1;
    inst_ready_in = 1'b1;
    wait_drain("backpressure", 40);
  endtask

  task automatic test_gnt_toggle();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    rom_lat = 1;
    inst_ready_in = 1'b1;
    push_stream(32'h0, 8);
    mon_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rom_gnt_in = pat[i % 4];
      @(negedge clk);
      if (i >= 1 && i <= 3) begin
        total++;
        if (rom_req_out !== 1'b1 || rom_addr_out !== 32'h4) begin
          bad++;
          $display("FAIL hold_addr i=%0d got=%b/%h required=1/4", i, rom_req_out, rom_addr_out);
        end
      end
      tick();
    end
    wait_drain("gnt_toggle", 30);
  endtask

  task automatic test_redirect();
    do_reset();
    rom_lat = 3;
    inst_ready_in = 1'b0;
    rom_gnt_in = 1'b1;
    tick();
    tick();
    rom_gnt_in = 1'b0;
    repeat (3) tick();
    rom_gnt_in = 1'b1;
    tick();
    tick();
    redirect_valid_in = 1'b1;
    redirect_addr_in = 32'h0000_0103;
    @(negedge clk);
    total++;
    if (rom_req_out !== 1'b0 || inst_valid_out !== 1'b1) begin
      bad++;
      $display("FAIL redir_cycle got=%b/%b required=0/1", rom_req_out, inst_valid_out);
    end
    tick();
    redirect_valid_in = 1'b0;
    @(negedge clk);
    total++;
    if (rom_req_out !== 1'b1 || rom_addr_out !== 32'h100) begin
      bad++;
      $display("FAIL redir_req got=%b/%h required=1/100", rom_req_out, rom_addr_out);
    end
    total++;
    if (inst_valid_out !== 1'b0) begin
      bad++; $display("FAIL redir_flush got=%b required=0", inst_valid_out);
    end
    tick();
    push_stream(32'h100, 8);
    inst_ready_in = 1'b1;
    mon_en = 1'b1;
    wait_drain("redirect", 60);
  endtask

  task automatic test_double_redirect();
    do_reset();
    rom_lat = 2;
    inst_ready_in = 1'b0;
    rom_gnt_in = 1'b1;
    repeat (3) tick();
    redirect_valid_in = 1'b1;
    redirect_addr_in = 32'h0000_0300;
    @(negedge clk);
    total++;
    if (rom_rvalid_in !== 1'b1 || rom_req_out !== 1'b0) begin
      bad++;
      $display("FAIL dredir_first got=%b/%b required=1/0", rom_rvalid_in, rom_req_out);
    end
    tick();
    redirect_addr_in = 32'h0000_0200;
    @(negedge clk);
    total++;
    if (rom_req_out !== 1'b0) begin
      bad++; $display("FAIL dredir_second got=%b required=0", rom_req_out);
    end
    tick();
    redirect_valid_in = 1'b0;
    @(negedge clk);
    total++;
    if (rom_req_out !== 1'b1 || rom_addr_out !== 32'h200) begin
      bad++;
      $display("FAIL dredir_req got=%b/%h required=1/200", rom_req_out, rom_addr_out);
    end
    tick();
    push_stream(32'h200, 8);
    inst_ready_in = 1'b1;
    mon_en = 1'b1;
    wait_drain("double_redirect", 50);
  endtask

  task automatic test_wrap();
    logic [31:0] want [3] = '{32'hffff_fff8, 32'hffff_fffc, 32'h0000_0000};
    do_reset();
    rom_lat = 1;
    rom_gnt_in = 1'b1;
    inst_ready_in = 1'b1;
    redirect_valid_in = 1'b1;
    redirect_addr_in = 32'hffff_fff8;
    tick();
    redirect_valid_in = 1'b0;
    push_stream(32'hffff_fff8, 6);
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (rom_addr_out !== want[i]) begin
        bad++;
        $display("FAIL wrap_addr i=%0d got=%h required=%h", i, rom_addr_out, want[i]);
      end
      tick();
    end
    wait_drain("wrap", 30);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_gnt_toggle();
    test_redirect();
    test_double_redirect();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
